// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - Wishbone B4 slave RAM with byte lanes, linear/wrap bursts, wait states and range error
module wb_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int unsigned           DEPTH = 1 << ADDR_WIDTH;
  localparam logic [32:0]           SPAN  = 33'(DEPTH) << 2;
  localparam logic [3:0]            WS    = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] MASK4  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] MASK8  = ADDR_WIDTH'(7);
  localparam logic [ADDR_WIDTH-1:0] MASK16 = ADDR_WIDTH'(15);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_ERR} state_t;

  logic [31:0]           mem_q [DEPTH];
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            bte_q;
  logic                  burst_q;
  logic                  err_pend_q;
  logic [3:0]            wait_q;
  logic                  ack_q;
  logic                  err_q;
  logic [31:0]           dat_q;

  logic [31:0]           offset;
  logic                  in_range;
  logic                  req;
  logic                  beat_done;
  logic                  last_beat;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] addr_d;

  assign offset    = wb_adr_i - BASE_ADDR;
  assign in_range  = (wb_adr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign req       = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign beat_done = (state_q == S_BEAT) & wb_cyc_i & wb_stb_i & ack_q;
  assign last_beat = ~burst_q | (wb_cti_i == 3'b111);
  assign mem_we    = beat_done & wb_we_i & ~rst;

  // Wrap bursts only advance the low bits selected by the mask; linear uses all bits.
  always_comb begin
    wrap_mask = '1;
    case (bte_q)
      2'b01:   wrap_mask = MASK4;
      2'b10:   wrap_mask = MASK8;
      2'b11:   wrap_mask = MASK16;
      default: wrap_mask = '1;
    endcase
    addr_d = (addr_q & ~wrap_mask) | ((addr_q + 1'b1) & wrap_mask);
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (wb_sel_i[k]) mem_q[addr_q][8*k +: 8] <= wb_dat_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      bte_q      <= 2'b00;
      burst_q    <= 1'b0;
      err_pend_q <= 1'b0;
      wait_q     <= 4'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            addr_q     <= offset[ADDR_WIDTH+1:2];
            bte_q      <= wb_bte_i;
            burst_q    <= (wb_cti_i == 3'b010);
            err_pend_q <= ~in_range;
            if (WAIT_STATES != 0) begin
              state_q <= S_WAIT;
              wait_q  <= WS - 4'd1;
            end else if (!in_range) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_BEAT;
              ack_q   <= 1'b1;
              dat_q   <= mem_q[offset[ADDR_WIDTH+1:2]];
            end
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            state_q <= S_IDLE;
          end else if (wait_q != 4'd0) begin
            wait_q <= wait_q - 4'd1;
          end else if (err_pend_q) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            state_q <= S_BEAT;
            ack_q   <= wb_stb_i;
            dat_q   <= mem_q[addr_q];
          end
        end
        S_BEAT: begin
          if (!wb_cyc_i) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
          end else if (beat_done) begin
            addr_q <= addr_d;
            if (last_beat) begin
              state_q <= S_IDLE;
              ack_q   <= 1'b0;
            end else begin
              ack_q <= 1'b1;
              dat_q <= mem_q[addr_d];
            end
          end else begin
            // Stall or pending beat: present data for the held address once stb is seen.
            ack_q <= wb_stb_i;
            dat_q <= mem_q[addr_q];
          end
        end
        default: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_mem_responder.sv
// tb/tb_wb_mem_responder.sv - scoreboard bench for wb_mem_responder (ADDR_WIDTH=10, BASE 0, one wait state)
module tb_wb_mem_responder;

  localparam int WS    = 1;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;

  wb_mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] sb [$];
  int          ba [16];
  logic [31:0] bd [16];
  int          bn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int a, input logic [1:0] bte);
    int n;
    if (bte == 2'b00) return (a + 1) % DEPTH;
    n = 4 << (bte - 1);
    return a - (a % n) + ((a % n) + 1) % n;
  endfunction

  function automatic void model_write(input int w, input logic [3:0] sel, input logic [31:0] d);
    for (int k = 0; k < 4; k++)
      if (sel[k]) model[w][8*k +: 8] = d[8*k +: 8];
  endfunction

  // Every completed read beat pops the scoreboard.
  always @(negedge clk) begin
    if (!rst && wb_cyc_i && wb_stb_i && wb_ack_o && !wb_we_i) begin
      if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("rdata", wb_dat_o, sb.pop_front());
    end
    if (wb_ack_o && wb_err_o) check("ack_err_excl", 32'd1, 32'd0);
  end

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 32'd0;
    wb_cti_i = 3'b000; wb_bte_i = 2'b00; wb_sel_i = 4'h0; wb_dat_i = 32'd0;
  endtask

  task automatic classic(input bit w, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] d, input bit exp_err);
    int lat;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w; wb_adr_i = adr;
    wb_sel_i = sel; wb_dat_i = d; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
    if (!w && !exp_err) sb.push_back(model[adr[11:2]]);
    lat = 0;
    while (!(wb_ack_o || wb_err_o) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("classic_lat", 32'(lat), 32'(WS + 1));
    check("classic_ack", {31'd0, wb_ack_o}, {31'd0, !exp_err});
    check("classic_err", {31'd0, wb_err_o}, {31'd0, exp_err});
    if (w && !exp_err) model_write(adr[11:2], sel, d);
    @(posedge clk); #1;
    idle_bus();
    check("classic_gap", {31'd0, wb_ack_o | wb_err_o}, 32'd0);
  endtask

  task automatic drive_beat(input int i);
    wb_adr_i = 32'(ba[i]) << 2;
    wb_dat_i = bd[i];
    wb_cti_i = (i == bn - 1) ? 3'b111 : 3'b010;
  endtask

  task automatic burst(input bit w, input logic [31:0] adr, input logic [1:0] bte,
                       input int n, input int stall_at, input int abort_at);
    int i, cnt, first;
    bit comp;
    bn = n;
    ba[0] = int'(adr[11:2]);
    for (int k = 0; k < n; k++) begin
      if (k > 0) ba[k] = nxt(ba[k-1], bte);
      bd[k] = $urandom;
      if (!w) sb.push_back(model[ba[k]]);
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w; wb_sel_i = 4'hF; wb_bte_i = bte;
    drive_beat(0);
    i = 0; cnt = 0; first = -1;
    while (i < n && cnt < 200) begin
      @(negedge clk);
      comp = wb_ack_o && wb_stb_i;
      if (wb_ack_o && first < 0) first = cnt;
      @(posedge clk); #1;
      cnt++;
      if (comp) begin
        if (w) model_write(ba[i], 4'hF, bd[i]);
        i++;
        if (i == abort_at) begin
          rst = 1'b1;
          drive_beat(i);
          @(posedge clk); #1;
          check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
          check("rst_err", {31'd0, wb_err_o}, 32'd0);
          check("rst_dat", wb_dat_o, 32'd0);
          rst = 1'b0;
          idle_bus();
          return;
        end
        if (i == stall_at && i < n) begin
          wb_stb_i = 1'b0;
          @(posedge clk); #1;
          @(negedge clk);
          check("stall_ack", {31'd0, wb_ack_o}, 32'd0);
          @(posedge clk); #1;
          wb_stb_i = 1'b1;
        end
        if (i < n) drive_beat(i);
      end
    end
    if (i < n) check("burst_timeout", 32'(i), 32'(n));
    check("burst_end_ack", {31'd0, wb_ack_o}, 32'd0);
    if (stall_at == 0) begin
      check("burst_first_ack", 32'(first), 32'(WS + 1));
      check("burst_cycles", 32'(cnt), 32'(WS + n + 1));
    end
    idle_bus();
  endtask

  initial begin
    rst = 1'b1;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'd0, wb_ack_o}, 32'd0);
    check("reset_err", {31'd0, wb_err_o}, 32'd0);
    check("reset_rty", {31'd0, wb_rty_o}, 32'd0);
    check("reset_dat", wb_dat_o, 32'd0);
    rst = 1'b0;

    classic(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    classic(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);

    classic(1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0);
    classic(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0);
    check("byte_lane_model", model[8], 32'h11BB33DD);
    classic(1'b0, 32'h20, 4'hF, 32'h0, 1'b0);

    burst(1'b1, 32'h30, 2'b00, 4, 0, 0);
    burst(1'b0, 32'h38, 2'b01, 4, 0, 0);

    burst(1'b1, 32'h100, 2'b00, 8, 3, 0);
    burst(1'b0, 32'h100, 2'b00, 8, 0, 0);
    burst(1'b0, 32'h114, 2'b10, 8, 0, 0);

    classic(1'b1, 32'h0, 4'hF, 32'h0BADF00D, 1'b0);
    classic(1'b0, 32'h1000, 4'hF, 32'h0, 1'b1);
    classic(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b1);
    classic(1'b0, 32'h0, 4'hF, 32'h0, 1'b0);

    classic(1'b1, 32'h208, 4'hF, 32'h55555555, 1'b0);
    burst(1'b1, 32'h200, 2'b00, 4, 0, 2);
    classic(1'b0, 32'h200, 4'hF, 32'h0, 1'b0);
    classic(1'b0, 32'h204, 4'hF, 32'h0, 1'b0);
    classic(1'b0, 32'h208, 4'hF, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
